// File: rtl/spad_line_buffer_pkg.sv
// spad_line_buffer_pkg: shared network sizes and index helpers for the scratchpad line buffer
package spad_line_buffer_pkg;
  localparam int SPAD_KERNEL_SIZE = 5;
  localparam int SPAD_FEATURE_WIDTH = 16;
  localparam int SPAD_DATA_BUS_WIDTH = 128;
  localparam int SPAD_DEPTH_WORDS = 16;
  localparam int SPAD_R = SPAD_DATA_BUS_WIDTH / SPAD_FEATURE_WIDTH;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b >= n) ? a + b - n : a + b;
  endfunction
endpackage

// File: rtl/spad_asym_line.sv
// spad_asym_line: one wide-in/narrow-out line FIFO, whole words in, single elements out
module spad_asym_line
  import spad_line_buffer_pkg::*;
#(
  parameter int FEATURE_WIDTH = SPAD_FEATURE_WIDTH,
  parameter int DATA_BUS_WIDTH = SPAD_DATA_BUS_WIDTH,
  parameter int DEPTH_WORDS = SPAD_DEPTH_WORDS
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [DATA_BUS_WIDTH-1:0] wr_data,
  input  logic                      rd_en,
  output logic [FEATURE_WIDTH-1:0]  rd_elem,
  output logic                      empty,
  output logic                      full
);
  localparam int R = DATA_BUS_WIDTH / FEATURE_WIDTH;
  localparam int EW = idx_w(R);
  localparam int AW = idx_w(DEPTH_WORDS);
  localparam int CW = $clog2(DEPTH_WORDS + 1);
  logic [DATA_BUS_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] elem;
  logic [CW-1:0] count;
  logic last, pop_word;
  assign last = elem == EW'(R - 1);
  // a word only leaves the occupancy count once its final element is consumed
  assign pop_word = rd_en && last;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH_WORDS);
  assign rd_elem = mem[rd_ptr][elem * FEATURE_WIDTH +: FEATURE_WIDTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      elem <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH_WORDS - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_en) elem <= last ? '0 : elem + 1'b1;
      if (pop_word) rd_ptr <= (rd_ptr == AW'(DEPTH_WORDS - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop_word);
    end
  end
endmodule

// File: rtl/spad_line_buffer.sv
// spad_line_buffer: NUM_LINES lockstep line FIFOs presenting a rotatable kernel-window column
module spad_line_buffer
  import spad_line_buffer_pkg::*;
#(
  parameter int NUM_LINES = SPAD_KERNEL_SIZE,
  parameter int FEATURE_WIDTH = SPAD_FEATURE_WIDTH,
  parameter int DATA_BUS_WIDTH = SPAD_DATA_BUS_WIDTH,
  parameter int DEPTH_WORDS = 16,
  parameter int LINE_IDX_W = $clog2(NUM_LINES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               wr_auto,
  input  logic [LINE_IDX_W-1:0]              wr_line,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [DATA_BUS_WIDTH-1:0]          wr_data,
  input  logic                               rd_en,
  input  logic                               rd_rotate,
  output logic                               rd_valid,
  output logic [NUM_LINES*FEATURE_WIDTH-1:0] rd_data,
  output logic [NUM_LINES-1:0]               line_empty,
  output logic [NUM_LINES-1:0]               line_full,
  output logic                               group_empty,
  output logic                               group_full
);
  logic clear, wr_acc, rd_acc;
  logic [LINE_IDX_W-1:0] auto_ptr, base, wr_tgt;
  logic [FEATURE_WIDTH-1:0] line_elem [NUM_LINES];
  logic [NUM_LINES*FEATURE_WIDTH-1:0] col;
  assign clear = rst || flush;
  assign wr_tgt = wr_auto ? auto_ptr : wr_line;
  assign group_empty = |line_empty;
  assign group_full = &line_full;
  assign wr_acc = wr_valid && wr_ready && !clear;
  assign rd_acc = rd_en && !group_empty && !clear;
  // out-of-range explicit targets never match a line, so they read as not ready and are dropped
  always_comb begin
    wr_ready = 1'b0;
    for (int i = 0; i < NUM_LINES; i++)
      if (wr_tgt == LINE_IDX_W'(i)) wr_ready = !line_full[i];
  end
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    spad_asym_line #(
      .FEATURE_WIDTH(FEATURE_WIDTH),
      .DATA_BUS_WIDTH(DATA_BUS_WIDTH),
      .DEPTH_WORDS(DEPTH_WORDS)
    ) u_line (
      .clk(clk),
      .clear(clear),
      .wr_en(wr_acc && wr_tgt == LINE_IDX_W'(i)),
      .wr_data(wr_data),
      .rd_en(rd_acc),
      .rd_elem(line_elem[i]),
      .empty(line_empty[i]),
      .full(line_full[i])
    );
  end
  always_comb begin
    col = '0;
    for (int k = 0; k < NUM_LINES; k++)
      col[k*FEATURE_WIDTH +: FEATURE_WIDTH] = line_elem[wrap_add(int'(base), k, NUM_LINES)];
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
      base <= '0;
      auto_ptr <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= col;
      if (rd_rotate) base <= (base == LINE_IDX_W'(NUM_LINES - 1)) ? '0 : base + 1'b1;
      if (wr_acc && wr_auto) auto_ptr <= (auto_ptr == LINE_IDX_W'(NUM_LINES - 1)) ? '0 : auto_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_spad_line_buffer.sv
// tb_spad_line_buffer: directed and randomized checks against a queue-based window model
module tb_spad_line_buffer;
  localparam int N = 5;
  localparam int FW = 16;
  localparam int BW = 128;
  localparam int R = BW / FW;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, flush = 0, wr_auto = 0, wr_valid = 0, rd_en = 0, rd_rotate = 0;
  logic [2:0] wr_line = 0;
  logic [BW-1:0] wr_data = 0;
  logic wr_ready, rd_valid, group_empty, group_full;
  logic [N*FW-1:0] rd_data;
  logic [N-1:0] line_empty, line_full;
  int n_cmp = 0, n_err = 0;
  logic [FW-1:0] q [N][$];
  int base = 0, aptr = 0;
  logic [N*FW-1:0] exp_data = 0;
  logic exp_valid = 0;

  spad_line_buffer #(.NUM_LINES(N), .FEATURE_WIDTH(FW), .DATA_BUS_WIDTH(BW), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_auto(wr_auto), .wr_line(wr_line), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .rd_en(rd_en), .rd_rotate(rd_rotate), .rd_valid(rd_valid),
    .rd_data(rd_data), .line_empty(line_empty), .line_full(line_full), .group_empty(group_empty),
    .group_full(group_full));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N*FW-1:0] got, input logic [N*FW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int words(input int i);
    return (q[i].size() + R - 1) / R;
  endfunction

  function automatic logic [BW-1:0] mk_word(input int b);
    logic [BW-1:0] w;
    for (int e = 0; e < R; e++) w[e*FW +: FW] = FW'(b + e);
    return w;
  endfunction

  task automatic step(input bit r, input bit f, input bit a, input int l, input bit v,
                      input logic [BW-1:0] d, input bit re, input bit ro);
    int tgt;
    bit rdy, rok;
    logic [N-1:0] ee, ef;
    rst = r; flush = f; wr_auto = a; wr_line = 3'(l); wr_valid = v; wr_data = d; rd_en = re; rd_rotate = ro;
    #1;
    tgt = a ? aptr : l;
    rdy = tgt < N && words(tgt) < DEPTH;
    check("wr_ready", wr_ready, rdy);
    @(posedge clk);
    if (r || f) begin
      for (int i = 0; i < N; i++) q[i].delete();
      base = 0; aptr = 0; exp_data = 0; exp_valid = 0;
    end else begin
      rok = re;
      for (int i = 0; i < N; i++) if (q[i].size() == 0) rok = 0;
      exp_valid = rok;
      if (rok) for (int k = 0; k < N; k++) exp_data[k*FW +: FW] = q[(base + k) % N].pop_front();
      if (v && rdy) begin
        for (int e = 0; e < R; e++) q[tgt].push_back(d[e*FW +: FW]);
        if (a) aptr = (aptr + 1) % N;
      end
      if (ro) base = (base + 1) % N;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      ee[i] = q[i].size() == 0;
      ef[i] = words(i) == DEPTH;
    end
    check("rd_valid", rd_valid, exp_valid);
    check("rd_data", rd_data, exp_data);
    check("line_empty", line_empty, ee);
    check("line_full", line_full, ef);
    check("group_empty", group_empty, |ee);
    check("group_full", group_full, &ef);
  endtask

  task automatic idle(input bit ro);
    step(0, 0, 0, 0, 0, '0, 0, ro);
  endtask

  task automatic rd1();
    step(0, 0, 0, 0, 0, '0, 1, 0);
  endtask

  initial begin
    logic [N*FW-1:0] c;
    @(negedge clk);
    step(1, 0, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, 0, '0, 0, 0);
    idle(0); idle(0);
    check("t1_group_empty", group_empty, 1);
    check("t1_rd_data", rd_data, 0);
    check("t1_wr_ready", wr_ready, 1);
    // explicit load, then eight columns of known data
    for (int l = 0; l < N; l++) step(0, 0, 0, l, 1, mk_word(l * 256), 0, 0);
    for (int j = 0; j < R; j++) begin
      rd1();
      for (int k = 0; k < N; k++) c[k*FW +: FW] = FW'(k * 256 + j);
      check("t2_col", rd_data, c);
      check("t2_valid", rd_valid, 1);
    end
    rd1();
    check("t2_ninth_valid", rd_valid, 0);
    check("t2_ninth_empty", group_empty, 1);
    // auto-increment write line selection
    for (int i = 0; i < 6; i++) step(0, 0, 1, 7, 1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    for (int j = 0; j < R; j++) rd1();
    check("t3_line_empty", line_empty, 5'b11110);
    step(0, 1, 0, 0, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 2, 1, mk_word(i * 16), 0, 0);
    check("t4_full2", line_full[2], 1);
    wr_line = 2; wr_auto = 0; #1;
    check("t4_ready2", wr_ready, 0);
    for (int l = 0; l < N; l++) if (l != 2) step(0, 0, 0, l, 1, mk_word(l), 0, 0);
    for (int j = 0; j < R - 1; j++) rd1();
    check("t4_full2_7", line_full[2], 1);
    rd1();
    check("t4_full2_8", line_full[2], 0);
    // window rotation
    step(0, 1, 0, 0, 0, '0, 0, 0);
    for (int l = 0; l < N; l++) step(0, 0, 0, l, 1, mk_word(l * 256), 0, 0);
    idle(1); idle(1);
    rd1();
    check("t5_lane0", rd_data[0 +: FW], 16'h0200);
    check("t5_lane3", rd_data[3*FW +: FW], 16'h0000);
    check("t5_lane4", rd_data[4*FW +: FW], 16'h0100);
    idle(1); idle(1); idle(1);
    rd1();
    check("t5_base0_lane0", rd_data[0 +: FW], 16'h0001);
    check("t5_base0_lane1", rd_data[FW +: FW], 16'h0101);
    // reset and flush override a simultaneous read and write
    step(0, 0, 0, 1, 1, mk_word(9), 0, 0);
    step(1, 0, 0, 1, 1, mk_word(9), 1, 0);
    check("t6_rst_empty", line_empty, 5'b11111);
    check("t6_rst_valid", rd_valid, 0);
    check("t6_rst_data", rd_data, 0);
    for (int l = 0; l < N; l++) step(0, 0, 0, l, 1, mk_word(l), 0, 0);
    rd1();
    step(0, 1, 0, 1, 1, mk_word(9), 1, 1);
    check("t6_flush_empty", line_empty, 5'b11111);
    check("t6_flush_valid", rd_valid, 0);
    check("t6_flush_data", rd_data, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0, 1'($urandom), $urandom_range(0, 7),
           $urandom_range(0, 2) != 0, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
